input_debouncer: RTL and testbench

- Sits directly upstream of the pin-inversion stage on ui_in[0].
- Takes the raw, asynchronous pad input and synchronises it into clk.
- Debounces it with a stability counter.
- Outputs a clean level that feeds the inversion stage, plus one-cycle rise/fall pulses and an 8-bit committed-transition counter for observation on spare outputs.

---
 rtl/input_debouncer.sv | 138 +++++++++++++
 tb/tb_input_debouncer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Purpose : synchronise and debounce one raw pad input into a clean level,
//           with one-cycle rise/fall pulses and a wrapping 8-bit commit counter.
// Latency : a stable input change reaches dout DEBOUNCE_CYCLES+1 edges after it
//           is first sampled (2 synchroniser edges, then DEBOUNCE_CYCLES-1 more).
// Backpressure: none; free-running, en=0 freezes dout and discards qualification.
// Ports   : clk, rst (sync, active-high), en, din (async), clr_count ->
//           dout, rise, fall, edge_count[7:0], busy.
module input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       din,
   input  logic       clr_count,
   output logic       dout,
   output logic       rise,
   output logic       fall,
   output logic [7:0] edge_count,
   output logic       busy
);

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } state_t;

   // Counter value on which the pending change is committed.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             busy_q, busy_d;
   logic [7:0]       edge_count_q, edge_count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic             commit;

   always_comb begin
      sync1_d      = din;
      sync2_d      = sync1_q;
      state_d      = state_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      rise_d       = 1'b0;
      fall_d       = 1'b0;
      edge_count_d = edge_count_q;
      commit       = 1'b0;

      if (!en) begin
         // Disabled: keep the level, drop any partial qualification.
         state_d = STABLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            STABLE: begin
               if (sync2_q != dout_q) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     // A single differing sample is enough; no pending phase.
                     commit = 1'b1;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     state_d = PENDING;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            PENDING: begin
               if (sync2_q == dout_q) begin
                  // Input bounced back before qualifying: glitch rejected.
                  cnt_d   = '0;
                  state_d = STABLE;
               end else if (cnt_q == LAST) begin
                  commit = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (commit) begin
         dout_d       = sync2_q;
         rise_d       = sync2_q;
         fall_d       = ~sync2_q;
         cnt_d        = '0;
         state_d      = STABLE;
         edge_count_d = edge_count_q + 8'd1;
      end

      // Clear takes priority over a same-edge increment.
      if (clr_count) begin
         edge_count_d = '0;
      end

      busy_d = (state_d == PENDING);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         dout_q       <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         busy_q       <= 1'b0;
         edge_count_q <= '0;
         cnt_q        <= '0;
         state_q      <= STABLE;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         dout_q       <= dout_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         busy_q       <= busy_d;
         edge_count_q <= edge_count_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
      end
   end

   assign dout       = dout_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign edge_count = edge_count_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a per-edge vector table plus hand-written
// sequences for clear/commit collision, reset mid-pending, counter wrap,
// fast toggling, and the DEBOUNCE_CYCLES=1 variant.
module tb_input_debouncer;

   logic       clk = 1'b0;
   logic       rst, en, din, clr_count;
   logic       dout, rise, fall, busy;
   logic [7:0] edge_count;
   logic       dout1, rise1, fall1, busy1;
   logic [7:0] edge_count1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_count(clr_count),
      .dout(dout), .rise(rise), .fall(fall), .edge_count(edge_count), .busy(busy)
   );

   input_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_count(clr_count),
      .dout(dout1), .rise(rise1), .fall(fall1), .edge_count(edge_count1), .busy(busy1)
   );

   typedef struct {
      logic       rst, en, din, clr;
      logic       dout, rise, fall, busy;
      logic [7:0] cnt;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vecs [NVEC];

   function automatic vec_t mk(logic r, logic e, logic d, logic c,
                               logic o, logic ri, logic fa, logic b, logic [7:0] n);
      vec_t v;
      v.rst = r; v.en = e; v.din = d; v.clr = c;
      v.dout = o; v.rise = ri; v.fall = fa; v.busy = b; v.cnt = n;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one set of inputs, take one rising edge, sample just after it.
   task automatic tick(input logic r, input logic e, input logic d, input logic c);
      rst = r; en = e; din = d; clr_count = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic o, input logic ri,
                            input logic fa, input logic b, input int n);
      chk({tag, ".dout"}, int'(dout), int'(o));
      chk({tag, ".rise"}, int'(rise), int'(ri));
      chk({tag, ".fall"}, int'(fall), int'(fa));
      chk({tag, ".busy"}, int'(busy), int'(b));
      chk({tag, ".edge_count"}, int'(edge_count), n);
   endtask

   initial begin
      int rises, falls, both, base_cnt, changes;
      logic d, dout_start;

      rst = 1'b1; en = 1'b1; din = 1'b0; clr_count = 1'b0;

      // Idle after reset: nothing may move with din held low.
      tick(1, 1, 0, 0);
      check_all("reset", 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         tick(0, 1, 0, 0);
         check_all($sformatf("idle%0d", i), 0, 0, 0, 0, 0);
      end

      // Per-edge table: clean rise, rejected low glitch, en=0 hold then re-enable.
      vecs[0]  = mk(1,1,0,0, 0,0,0,0,0);
      vecs[1]  = mk(0,1,0,0, 0,0,0,0,0);
      vecs[2]  = mk(0,1,0,0, 0,0,0,0,0);
      vecs[3]  = mk(0,1,0,0, 0,0,0,0,0);
      vecs[4]  = mk(0,1,1,0, 0,0,0,0,0);
      vecs[5]  = mk(0,1,1,0, 0,0,0,0,0);
      vecs[6]  = mk(0,1,1,0, 0,0,0,1,0);
      vecs[7]  = mk(0,1,1,0, 0,0,0,1,0);
      vecs[8]  = mk(0,1,1,0, 0,0,0,1,0);
      vecs[9]  = mk(0,1,1,0, 1,1,0,0,1);
      vecs[10] = mk(0,1,1,0, 1,0,0,0,1);
      vecs[11] = mk(0,1,0,0, 1,0,0,0,1);
      vecs[12] = mk(0,1,0,0, 1,0,0,0,1);
      vecs[13] = mk(0,1,0,0, 1,0,0,1,1);
      vecs[14] = mk(0,1,1,0, 1,0,0,1,1);
      vecs[15] = mk(0,1,1,0, 1,0,0,1,1);
      vecs[16] = mk(0,1,1,0, 1,0,0,0,1);
      vecs[17] = mk(0,1,1,0, 1,0,0,0,1);
      vecs[18] = mk(0,0,0,0, 1,0,0,0,1);
      vecs[19] = mk(0,0,0,0, 1,0,0,0,1);
      vecs[20] = mk(0,0,0,0, 1,0,0,0,1);
      vecs[21] = mk(0,0,0,0, 1,0,0,0,1);
      vecs[22] = mk(0,1,0,0, 1,0,0,1,1);
      vecs[23] = mk(0,1,0,0, 1,0,0,1,1);
      vecs[24] = mk(0,1,0,0, 1,0,0,1,1);
      vecs[25] = mk(0,1,0,0, 0,0,1,0,2);
      vecs[26] = mk(0,1,0,0, 0,0,0,0,2);
      for (int i = 0; i < NVEC; i++) begin
         tick(vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].clr);
         check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rise,
                   vecs[i].fall, vecs[i].busy, int'(vecs[i].cnt));
      end

      // Bring edge_count to 5 with dout=1, then clear on the committing edge.
      for (int k = 0; k < 3; k++) begin
         d = (k % 2 == 0);
         for (int i = 0; i < 10; i++) tick(0, 1, d, 0);
      end
      chk("pre_clr.edge_count", int'(edge_count), 5);
      chk("pre_clr.dout", int'(dout), 1);
      for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
      chk("pre_clr.dout_held", int'(dout), 1);
      tick(0, 1, 0, 1);
      check_all("clr_commit", 0, 0, 1, 0, 0);
      tick(0, 1, 0, 0);
      check_all("clr_after", 0, 0, 0, 0, 0);

      // Reset while a 1->0 change is pending with dout=1.
      for (int i = 0; i < 10; i++) tick(0, 1, 1, 0);
      chk("pre_rst.dout", int'(dout), 1);
      chk("pre_rst.edge_count", int'(edge_count), 1);
      for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
      chk("pre_rst.busy", int'(busy), 1);
      tick(1, 1, 0, 1);
      check_all("rst_pending", 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) tick(0, 1, 0, 0);
      check_all("post_rst", 0, 0, 0, 0, 0);

      // 256 clean toggles: counter wraps to 0, 128 pulses of each kind.
      rises = 0; falls = 0; both = 0; d = 1'b0;
      for (int k = 0; k < 256; k++) begin
         d = ~d;
         for (int i = 0; i < 10; i++) begin
            tick(0, 1, d, 0);
            rises += int'(rise);
            falls += int'(fall);
            both  += int'(rise & fall);
         end
      end
      chk("wrap.edge_count", int'(edge_count), 0);
      chk("wrap.rises", rises, 128);
      chk("wrap.falls", falls, 128);
      chk("wrap.both_high", both, 0);
      chk("wrap.dout", int'(dout), 0);

      // Toggling every cycle must never qualify.
      base_cnt = int'(edge_count); dout_start = dout;
      rises = 0; falls = 0; changes = 0;
      for (int i = 0; i < 30; i++) begin
         tick(0, 1, (i % 2 == 0), 0);
         rises += int'(rise);
         falls += int'(fall);
         if (dout != dout_start) changes++;
      end
      chk("toggle.edge_count", int'(edge_count), base_cnt);
      chk("toggle.pulses", rises + falls, 0);
      chk("toggle.dout_changes", changes, 0);

      // DEBOUNCE_CYCLES=1: commit on the third edge, never busy.
      tick(1, 1, 0, 0);
      chk("n1.reset_dout", int'(dout1), 0);
      tick(0, 1, 1, 0);
      chk("n1.e1_dout", int'(dout1), 0);
      tick(0, 1, 1, 0);
      chk("n1.e2_dout", int'(dout1), 0);
      chk("n1.e2_busy", int'(busy1), 0);
      tick(0, 1, 1, 0);
      chk("n1.e3_dout", int'(dout1), 1);
      chk("n1.e3_rise", int'(rise1), 1);
      chk("n1.e3_busy", int'(busy1), 0);
      chk("n1.e3_edge_count", int'(edge_count1), 1);
      tick(0, 1, 1, 0);
      chk("n1.e4_rise", int'(rise1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
